// File: rtl/cond_logic_if.sv
`default_nettype none
// ============================================================================
// Module   : cond_logic_if
// Brief    : Decoder-to-conditional-stage bus: strobes, flags and gated enables.
// Revision : 1.0
// ============================================================================
interface cond_logic_if;
    logic       en;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : cond_logic
// Brief    : ARM conditional-execution stage: NZCV flag storage, condition
//            evaluation and gating of the PC/register/memory write strobes.
// Revision : 1.0
// ============================================================================
module cond_logic #(
    parameter bit COND_NV_EXEC = 1'b0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    cond_logic_if.slave bus
);

    localparam logic [3:0] c_eq = 4'b0000;
    localparam logic [3:0] c_ne = 4'b0001;
    localparam logic [3:0] c_cs = 4'b0010;
    localparam logic [3:0] c_cc = 4'b0011;
    localparam logic [3:0] c_mi = 4'b0100;
    localparam logic [3:0] c_pl = 4'b0101;
    localparam logic [3:0] c_vs = 4'b0110;
    localparam logic [3:0] c_vc = 4'b0111;
    localparam logic [3:0] c_hi = 4'b1000;
    localparam logic [3:0] c_ls = 4'b1001;
    localparam logic [3:0] c_ge = 4'b1010;
    localparam logic [3:0] c_lt = 4'b1011;
    localparam logic [3:0] c_gt = 4'b1100;
    localparam logic [3:0] c_le = 4'b1101;
    localparam logic [3:0] c_al = 4'b1110;

    // NZ and CV are independent fields so FlagW can update either alone.
    logic [1:0] r_nz;
    logic [1:0] r_cv;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_cond_ex;
    logic w_update;

    assign w_n = r_nz[1];
    assign w_z = r_nz[0];
    assign w_c = r_cv[1];
    assign w_v = r_cv[0];

    always_comb begin
        w_cond_ex = COND_NV_EXEC;
        case (bus.Cond)
            c_eq:    w_cond_ex = w_z;
            c_ne:    w_cond_ex = ~w_z;
            c_cs:    w_cond_ex = w_c;
            c_cc:    w_cond_ex = ~w_c;
            c_mi:    w_cond_ex = w_n;
            c_pl:    w_cond_ex = ~w_n;
            c_vs:    w_cond_ex = w_v;
            c_vc:    w_cond_ex = ~w_v;
            c_hi:    w_cond_ex = w_c & ~w_z;
            c_ls:    w_cond_ex = ~w_c | w_z;
            c_ge:    w_cond_ex = (w_n == w_v);
            c_lt:    w_cond_ex = (w_n != w_v);
            c_gt:    w_cond_ex = ~w_z & (w_n == w_v);
            c_le:    w_cond_ex = w_z | (w_n != w_v);
            c_al:    w_cond_ex = 1'b1;
            default: w_cond_ex = COND_NV_EXEC;
        endcase
    end

    // Condition sees pre-update flags; new flags appear for the next Cond.
    assign w_update = bus.en & w_cond_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz <= 2'b00;
            r_cv <= 2'b00;
        end else if (w_update) begin
            if (bus.FlagW[1]) r_nz <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) r_cv <= bus.ALUFlags[1:0];
        end
    end

    assign bus.CondEx   = w_cond_ex;
    assign bus.Flags    = {r_nz, r_cv};
    assign bus.PCSrc    = bus.en & bus.PCS  & w_cond_ex;
    assign bus.RegWrite = bus.en & bus.RegW & w_cond_ex & ~bus.NoWrite;
    assign bus.MemWrite = bus.en & bus.MemW & w_cond_ex;

endmodule
`default_nettype wire
